// File: rtl/alu_issue.sv
// alu_issue: decodes one MIPS R/I-type instruction per cycle into ALU control and operands,
// issued through an output register backed by a one-entry skid buffer. Optional macro: ALU_ISSUE_VAR_SHIFT_EN (sllv/srlv).
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rs,
    output logic [31:0] out_rt,
    output logic [3:0]  out_ctrl,
    output logic [4:0]  out_sa,
    output logic [4:0]  out_dst,
    output logic        out_wr,
    output logic        out_illegal
);
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SUBU = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLL  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;

    typedef struct packed {
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
        logic [3:0]        ctrl;
        logic [4:0]        sa;
        logic [REG_W-1:0]  dst;
        logic              wr;
        logic              illegal;
    } op_t;

    logic [5:0]               opcode;
    logic [5:0]               funct;
    logic signed [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0]        imm_zext;
    logic                     legal;
    op_t                      dec_p0;
    logic                     unused_rs_idx;

    assign opcode   = in_instr[31:26];
    assign funct    = in_instr[5:0];
    assign imm_sext = {{16{in_instr[15]}}, in_instr[15:0]};
    assign imm_zext = {16'h0000, in_instr[15:0]};
    // Register indices for rs arrive already resolved as in_rs_val.
    assign unused_rs_idx = &{1'b0, in_instr[25:21]};

    // Stage p0: combinational decode of the incoming instruction
    always_comb begin
        dec_p0    = '0;
        legal     = 1'b1;
        dec_p0.rs = in_rs_val;
        if (opcode == 6'h00) begin
            dec_p0.rt  = in_rt_val;
            dec_p0.dst = in_instr[15:11];
            case (funct)
                6'h20:   dec_p0.ctrl = ALU_ADD;
                6'h21:   dec_p0.ctrl = ALU_ADDU;
                6'h22:   dec_p0.ctrl = ALU_SUB;
                6'h23:   dec_p0.ctrl = ALU_SUBU;
                6'h24:   dec_p0.ctrl = ALU_AND;
                6'h25:   dec_p0.ctrl = ALU_OR;
                6'h26:   dec_p0.ctrl = ALU_XOR;
                6'h27:   dec_p0.ctrl = ALU_NOR;
                6'h2A:   dec_p0.ctrl = ALU_SLT;
                6'h2B:   dec_p0.ctrl = ALU_SLTU;
                6'h00: begin
                    dec_p0.ctrl = ALU_SLL;
                    dec_p0.sa   = in_instr[10:6];
                end
                6'h02: begin
                    dec_p0.ctrl = ALU_SRL;
                    dec_p0.sa   = in_instr[10:6];
                end
`ifdef ALU_ISSUE_VAR_SHIFT_EN
                6'h04: begin
                    dec_p0.ctrl = ALU_SLL;
                    dec_p0.sa   = in_rs_val[4:0];
                end
                6'h06: begin
                    dec_p0.ctrl = ALU_SRL;
                    dec_p0.sa   = in_rs_val[4:0];
                end
`endif
                default: legal = 1'b0;
            endcase
        end else begin
            dec_p0.dst = in_instr[20:16];
            dec_p0.rt  = imm_zext;
            case (opcode)
                6'h08: begin
                    dec_p0.ctrl = ALU_ADD;
                    dec_p0.rt   = imm_sext;
                end
                6'h09: begin
                    dec_p0.ctrl = ALU_ADDU;
                    dec_p0.rt   = imm_sext;
                end
                6'h0A: begin
                    dec_p0.ctrl = ALU_SLT;
                    dec_p0.rt   = imm_sext;
                end
                6'h0B: begin
                    dec_p0.ctrl = ALU_SLTU;
                    dec_p0.rt   = imm_sext;
                end
                6'h0C:   dec_p0.ctrl = ALU_AND;
                6'h0D:   dec_p0.ctrl = ALU_OR;
                6'h0E:   dec_p0.ctrl = ALU_XOR;
                6'h0F: begin
                    dec_p0.ctrl = ALU_SLL;
                    dec_p0.sa   = 5'd16;
                end
                default: legal = 1'b0;
            endcase
        end
        dec_p0.wr = legal;
        // Illegal ops still travel through the handshake, with an all-zero payload.
        if (!legal) begin
            dec_p0         = '0;
            dec_p0.illegal = 1'b1;
        end
    end

    op_t  o_p1;
    op_t  s_p1;
    logic vld_p1;
    logic s_full;
    logic accept;
    logic o_load;

    assign in_ready = !s_full;
    assign accept   = in_valid & in_ready;
    assign o_load   = !vld_p1 | out_ready;

    // Stage p1: output register and skid register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            s_full <= 1'b0;
            o_p1   <= '0;
        end else if (o_load) begin
            if (s_full) begin
                o_p1   <= s_p1;
                vld_p1 <= 1'b1;
                s_full <= 1'b0;
            end else begin
                vld_p1 <= accept;
                if (accept) begin
                    o_p1 <= dec_p0;
                end
            end
        end else if (accept) begin
            s_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!o_load && accept) begin
            s_p1 <= dec_p0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_rs      = o_p1.rs;
    assign out_rt      = o_p1.rt;
    assign out_ctrl    = o_p1.ctrl;
    assign out_sa      = o_p1.sa;
    assign out_dst     = o_p1.dst;
    assign out_wr      = o_p1.wr;
    assign out_illegal = o_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: scoreboard of decoded ops plus directed checks of decode, backpressure and reset.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs;
    logic [31:0] out_rt;
    logic [3:0]  out_ctrl;
    logic [4:0]  out_sa;
    logic [4:0]  out_dst;
    logic        out_wr;
    logic        out_illegal;
    logic [79:0] obs;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs(out_rs), .out_rt(out_rt), .out_ctrl(out_ctrl), .out_sa(out_sa),
        .out_dst(out_dst), .out_wr(out_wr), .out_illegal(out_illegal)
    );

    assign obs = {out_rs, out_rt, out_ctrl, out_sa, out_dst, out_wr, out_illegal};

    int          checks = 0;
    int          errors = 0;
    logic [79:0] sb[$];

    logic [5:0] r_fn [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06, 6'h3F};
    logic [5:0] i_op [0:9]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                6'h23, 6'h2B};

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode: {rs, rt, ctrl, sa, dst, wr, illegal}
    function automatic logic [79:0] model(input logic [31:0] ins, input logic [31:0] rsv,
                                          input logic [31:0] rtv);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  c;
        logic [4:0]  sa;
        logic [4:0]  d;
        logic [31:0] b;
        logic        ok;
        op = ins[31:26];
        fn = ins[5:0];
        ok = 1'b1;
        sa = 5'd0;
        c  = 4'h0;
        if (op == 6'h00) begin
            d = ins[15:11];
            b = rtv;
            case (fn)
                6'h20: c = 4'h1;
                6'h21: c = 4'h0;
                6'h22: c = 4'h9;
                6'h23: c = 4'h8;
                6'h24: c = 4'h2;
                6'h25: c = 4'h3;
                6'h26: c = 4'h6;
                6'h27: c = 4'h5;
                6'h2A: c = 4'hB;
                6'h2B: c = 4'hA;
                6'h00: begin c = 4'hC; sa = ins[10:6]; end
                6'h02: begin c = 4'hD; sa = ins[10:6]; end
`ifdef ALU_ISSUE_VAR_SHIFT_EN
                6'h04: begin c = 4'hC; sa = rsv[4:0]; end
                6'h06: begin c = 4'hD; sa = rsv[4:0]; end
`endif
                default: ok = 1'b0;
            endcase
        end else begin
            d = ins[20:16];
            b = (op inside {[6'h08:6'h0B]}) ? {{16{ins[15]}}, ins[15:0]} : {16'h0, ins[15:0]};
            case (op)
                6'h08: c = 4'h1;
                6'h09: c = 4'h0;
                6'h0A: c = 4'hB;
                6'h0B: c = 4'hA;
                6'h0C: c = 4'h2;
                6'h0D: c = 4'h3;
                6'h0E: c = 4'h6;
                6'h0F: begin c = 4'hC; sa = 5'd16; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) return 80'd1;
        return {rsv, b, c, sa, d, 1'b1, 1'b0};
    endfunction

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 24);
        r = $urandom;
        if (k < 15) return {6'h00, r[25:6], r_fn[k]};
        return {i_op[k-15], r[25:0]};
    endfunction

    // Scoreboard: pop on every output handshake, push on every input handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 80'(sb.size() != 0), 80'd1);
                if (sb.size() != 0) check("sb_data", obs, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(model(in_instr, in_rs_val, in_rt_val));
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        int n;
        n = 0;
        in_instr  = ins;
        in_rs_val = rs;
        in_rt_val = rt;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_in_ready", 80'(in_ready), 80'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] exp_a;
        logic [79:0] exp_b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 80'(out_valid), 80'd0);
        check("rst_in_ready", 80'(in_ready), 80'd1);
        check("rst_payload", obs, 80'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'h2128FFFF, 32'd5, 32'h77);
        check("addi_valid", 80'(out_valid), 80'd1);
        check("addi_ctrl", 80'(out_ctrl), 80'h1);
        check("addi_rt", 80'(out_rt), 80'hFFFFFFFF);
        check("addi_rs", 80'(out_rs), 80'd5);
        check("addi_dst", 80'(out_dst), 80'd8);
        check("addi_wr", 80'(out_wr), 80'd1);

        send(32'h3C011234, 32'hDEAD, 32'hBEEF);
        check("lui_ctrl", 80'(out_ctrl), 80'hC);
        check("lui_sa", 80'(out_sa), 80'd16);
        check("lui_rt", 80'(out_rt), 80'h00001234);
        send(32'h34215678, 32'h12340000, 32'h0);
        check("ori_valid", 80'(out_valid), 80'd1);
        check("ori_ctrl", 80'(out_ctrl), 80'h3);
        check("ori_rt", 80'(out_rt), 80'h00005678);

        send(32'h0000003F, 32'h1111, 32'h2222);
        check("ill_valid", 80'(out_valid), 80'd1);
        check("ill_flag", 80'(out_illegal), 80'd1);
        check("ill_wr", 80'(out_wr), 80'd0);
        check("ill_ctrl", 80'(out_ctrl), 80'h0);
        check("ill_rs", 80'(out_rs), 80'h0);

        send(32'h00221004, 32'h23, 32'hABCD);
`ifdef ALU_ISSUE_VAR_SHIFT_EN
        check("sllv_ctrl", 80'(out_ctrl), 80'hC);
        check("sllv_sa", 80'(out_sa), 80'd3);
        check("sllv_rt", 80'(out_rt), 80'hABCD);
`else
        check("sllv_illegal", 80'(out_illegal), 80'd1);
        check("sllv_wr", 80'(out_wr), 80'd0);
`endif
        @(posedge clk);
        #1;
        check("drain1_empty", 80'(sb.size()), 80'd0);
        check("drain1_valid", 80'(out_valid), 80'd0);

        // Backpressure: A held in O, B absorbed into S, C waits.
        exp_a = model(32'h00853020, 32'h10, 32'h20);
        exp_b = model(32'h2063FFF0, 32'h30, 32'h0);
        send(32'h00853020, 32'h10, 32'h20);
        out_ready = 1'b0;
        send(32'h2063FFF0, 32'h30, 32'h0);
        check("bp_in_ready_low", 80'(in_ready), 80'd0);
        check("bp_hold_a", obs, exp_a);
        fork
            send(32'h00A41822, 32'h99, 32'h11);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_stable", obs, exp_a);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("rel_o_is_b", obs, exp_b);
                check("rel_in_ready", 80'(in_ready), 80'd1);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("drain2_empty", 80'(sb.size()), 80'd0);

        // Random stream under random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) send(rand_instr(), $urandom, $urandom);
            end
            begin
                for (int k = 0; k < 150; k++) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain3_empty", 80'(sb.size()), 80'd0);

        // Reset while O and S are both full.
        out_ready = 1'b0;
        send(32'h01095025, 32'h5, 32'h6);
        send(32'h3C07ABCD, 32'h0, 32'h0);
        check("pre_rst_in_ready", 80'(in_ready), 80'd0);
        check("pre_rst_valid", 80'(out_valid), 80'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 80'(out_valid), 80'd0);
        check("mid_rst_in_ready", 80'(in_ready), 80'd1);
        check("mid_rst_payload", obs, 80'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(32'h3042F0F0, 32'hFFFF1234, 32'h0);
        check("post_rst_valid", 80'(out_valid), 80'd1);
        check("post_rst_data", obs, model(32'h3042F0F0, 32'hFFFF1234, 32'h0));
        @(posedge clk);
        #1;
        check("drain4_empty", 80'(sb.size()), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
